// File: rtl/bus_router_pkg.sv
// rtl/bus_router_pkg.sv - shared types and constants for the bus router
package bus_router_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  typedef enum logic {
    CAUSE_UNMAPPED = 1'b0,
    CAUSE_TIMEOUT  = 1'b1
  } fault_cause_e;

endpackage

// File: rtl/bus_router_decode.sv
// rtl/bus_router_decode.sv - combinational region decoder; lowest matching target index wins
module bus_router_decode #(
  parameter int                               TARGETS     = 4,
  parameter int                               REGION_BITS = 4,
  parameter logic [TARGETS*REGION_BITS-1:0]   REGION_MAP  = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int                               IDX_W       = 2
) (
  input  logic [REGION_BITS-1:0] region_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       index_o
);

  // Scan from the top down so the lowest matching entry is the last one written.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    for (int k = TARGETS - 1; k >= 0; k--) begin
      if (REGION_MAP[k*REGION_BITS +: REGION_BITS] == region_i) begin
        hit_o   = 1'b1;
        index_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bus_router.sv
// rtl/bus_router.sv - single-initiator address router; define BUS_ROUTER_TIMEOUT_EN for the ACTIVE timeout
module bus_router
  import bus_router_pkg::*;
#(
  parameter int                             TARGETS     = 4,
  parameter int                             REGION_BITS = 4,
  parameter logic [TARGETS*REGION_BITS-1:0] REGION_MAP  = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int                             TIMEOUT     = 1024
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_request,
  input  logic                      i_rw,
  input  logic [DATA_W-1:0]         i_address,
  input  logic [DATA_W-1:0]         i_wdata,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_ready,
  output logic                      o_fault,
  output logic [TARGETS-1:0]        o_t_request,
  output logic                      o_t_rw,
  output logic [DATA_W-1:0]         o_t_address,
  output logic [DATA_W-1:0]         o_t_wdata,
  input  logic [TARGETS*DATA_W-1:0] i_t_rdata,
  input  logic [TARGETS-1:0]        i_t_ready,
  output logic                      o_fault_status,
  output logic                      o_fault_cause,
  output logic [DATA_W-1:0]         o_fault_address,
  input  logic                      i_fault_clear
);

  localparam int IDX_W = $clog2(TARGETS);

  if (TARGETS < 2 || TARGETS > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("bus_router: unsupported TARGETS or TIMEOUT");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, dec_idx;
  logic                dec_hit;
  logic [TARGETS-1:0]  treq_q;
  logic                rw_q;
  logic [DATA_W-1:0]   addr_q, wdata_q, rdata_q, faddr_q;
  logic                fstatus_q;
  logic [DATA_W-1:0]   t_rdata [TARGETS];
  logic                sel_ready, timeout_hit, fault_entry;

  bus_router_decode #(
    .TARGETS     (TARGETS),
    .REGION_BITS (REGION_BITS),
    .REGION_MAP  (REGION_MAP),
    .IDX_W       (IDX_W)
  ) u_decode (
    .region_i (i_address[DATA_W-1 -: REGION_BITS]),
    .hit_o    (dec_hit),
    .index_o  (dec_idx)
  );

  for (genvar k = 0; k < TARGETS; k++) begin : g_rdata
    assign t_rdata[k] = i_t_rdata[k*DATA_W +: DATA_W];
  end

  assign sel_ready = i_t_ready[idx_q];

`ifdef BUS_ROUTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;
  fault_cause_e     fcause_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || state_q != ST_ACTIVE) cnt_q <= '0;
    else                                    cnt_q <= cnt_q + CNT_W'(1);
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n)         fcause_q <= CAUSE_UNMAPPED;
    else if (fault_entry)   fcause_q <= (state_q == ST_ACTIVE) ? CAUSE_TIMEOUT : CAUSE_UNMAPPED;
    else if (i_fault_clear) fcause_q <= CAUSE_UNMAPPED;
  end

  assign o_fault_cause = fcause_q;
`else
  assign timeout_hit   = 1'b0;
  assign o_fault_cause = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Target ready wins over a timeout that expires in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_request) state_d = dec_hit ? ST_ACTIVE : ST_FAULT;
      ST_ACTIVE: begin
        if (sel_ready)        state_d = ST_RESPOND;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_RESPOND: state_d = ST_IDLE;
      ST_FAULT:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_fault = 1'b0;
    o_rdata = '0;
    case (state_q)
      ST_RESPOND: begin
        o_ready = 1'b1;
        o_rdata = rdata_q;
      end
      ST_FAULT: begin
        o_ready = 1'b1;
        o_fault = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      treq_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && i_request && dec_hit) begin
        treq_q  <= TARGETS'(1) << dec_idx;
        rw_q    <= i_rw;
        addr_q  <= i_address;
        wdata_q <= i_wdata;
        idx_q   <= dec_idx;
      end else if (state_q == ST_ACTIVE && state_d != ST_ACTIVE) begin
        treq_q <= '0;
      end
      if (state_q == ST_ACTIVE && sel_ready) rdata_q <= t_rdata[idx_q];
    end
  end

  // A fault entry in the same cycle as a clear keeps the new record.
  assign fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      fstatus_q <= 1'b0;
      faddr_q   <= '0;
    end else if (fault_entry) begin
      fstatus_q <= 1'b1;
      faddr_q   <= (state_q == ST_IDLE) ? i_address : addr_q;
    end else if (i_fault_clear) begin
      fstatus_q <= 1'b0;
      faddr_q   <= '0;
    end
  end

  assign o_t_request     = treq_q;
  assign o_t_rw          = rw_q;
  assign o_t_address     = {{REGION_BITS{1'b0}}, addr_q[DATA_W-REGION_BITS-1:0]};
  assign o_t_wdata       = wdata_q;
  assign o_fault_status  = fstatus_q;
  assign o_fault_address = faddr_q;

endmodule
